sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The parameter DEPTH SHALL default to 512 and set the number of entries; it must be a power of 2 and at least 4.
REQ-002 The parameter DATA_WIDTH SHALL default to 64 and set the entry width in bits.
REQ-003 The parameter AFULL_THRESH SHALL default to DEPTH-4 and set the occupancy at or above which o_almost_full asserts.
REQ-004 The parameter AEMPTY_THRESH SHALL default to 4 and set the occupancy at or below which o_almost_empty asserts.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-007 i_rst  input  1  is the synchronous, active-high reset.
REQ-008 i_wr_en  input  1  is the write request.
REQ-009 i_wr_data  input  DATA_WIDTH  is the write data.
REQ-010 i_rd_en  input  1  is the read request (the pop acknowledge in FWFT mode).
REQ-011 o_rd_data  output  DATA_WIDTH  is the read data.
REQ-012 o_rd_valid  output  1  qualifies o_rd_data.
REQ-013 o_full, o_empty, o_almost_full and o_almost_empty  output  1 each  are the status flags.
REQ-014 o_count  output  $clog2(DEPTH)+1  is the current occupancy, 0..DEPTH.
REQ-015 o_overflow and o_underflow  output  1 each  are sticky error flags.

Function
REQ-016 Write and read pointers SHALL each be $clog2(DEPTH)+1 bits; the low bits address storage and the MSB is the wrap bit.
REQ-017 o_empty SHALL be 1 when the pointers are equal; o_full SHALL be 1 when the MSBs differ and the low bits are equal.
REQ-018 o_count SHALL equal wr_ptr minus rd_ptr, modulo 2^($clog2(DEPTH)+1).
REQ-019 o_almost_full SHALL be (o_count >= AFULL_THRESH); o_almost_empty SHALL be (o_count <= AEMPTY_THRESH).
REQ-020 All flags and o_count SHALL derive from registered pointers only, so they reflect an accepted access in the cycle after the accepting edge.
REQ-021 A write SHALL be accepted when i_wr_en=1 and o_full=0: data is stored at the write address and the write pointer increments.
REQ-022 A read SHALL be accepted when i_rd_en=1 and o_empty=0, and the read pointer increments.
REQ-023 A simultaneous write and read SHALL each be judged on the current flags:
  - When full, the read is accepted and the write is rejected.
  - When empty, the write is accepted and the read is rejected.
  - Otherwise both are accepted and o_count is unchanged.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 in the low bits and toggle the MSB, with no bubble.
REQ-025 An i_wr_en while o_full=1 SHALL set o_overflow; storage and pointers are untouched.
REQ-026 An i_rd_en while o_empty=1 SHALL set o_underflow; o_rd_data holds its value and o_rd_valid stays 0.
REQ-027 o_overflow and o_underflow SHALL stay set until reset.
REQ-028 In standard mode, o_rd_data SHALL be registered and load the head entry one cycle after an accepted read.
REQ-029 In standard mode, o_rd_valid SHALL pulse high for exactly that cycle; otherwise o_rd_data holds its last value.

Reset
REQ-030 With i_rst=1 at a rising edge, the block SHALL set:
  - both pointers = 0, o_count = 0;
  - o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0;
  - o_rd_data = 0, o_rd_valid = 0;
  - o_overflow = 0, o_underflow = 0.
REQ-031 Reset SHALL take priority over simultaneous i_wr_en/i_rd_en; mid-operation it discards all contents.
REQ-032 Storage array contents SHALL NOT be reset.

Configuration
REQ-033 Macro SYNC_FIFO_FWFT_EN SHALL, when defined, select first-word-fall-through mode:
  - o_rd_data presents the head entry combinationally from the read address, and o_rd_valid = !o_empty.
  - An accepted i_rd_en pops the head, and the next entry appears in the following cycle.
  - A write into an empty FIFO is visible on o_rd_data one cycle after the write edge.
REQ-034 With SYNC_FIFO_FWFT_EN undefined, standard registered-read mode (REQ-028, REQ-029) SHALL apply, with 1-cycle read latency.

Verification
All scenarios use DEPTH=8, DATA_WIDTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2.
REQ-035 Fill: reset, then write 0x01..0x08 on consecutive cycles -> o_almost_empty drops at count 3, o_almost_full rises at count 6, then o_full=1 and o_count=8.
REQ-036 Overflow and drain: at full, write 0xFF -> o_overflow=1 and o_count=8; then read 8 times (standard mode) -> o_rd_valid pulses carry 0x01..0x08 in order, then o_empty=1.
REQ-037 Wrap with simultaneous access: at count 4, assert write and read together for 20 cycles with incrementing data -> o_count stays 4, the output sequence is unbroken and in order, and the pointers wrap twice.
REQ-038 Underflow: with the FIFO empty, pulse i_rd_en -> o_underflow=1, o_rd_valid=0, o_rd_data unchanged, o_count=0.
REQ-039 Reset mid-operation: at count 5 with o_overflow=1, assert i_rst together with i_wr_en -> the next cycle shows o_count=0, o_empty=1 and o_overflow=0, and nothing is written.
REQ-040 FWFT (macro defined): write 0xA5 into an empty FIFO -> the next cycle shows o_rd_valid=1 and o_rd_data=0xA5 without i_rd_en; pulse i_rd_en -> o_empty=1 on the following cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous FIFO with pointer-derived status flags and sticky error flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo #(
  parameter int DEPTH         = 512,
  parameter int DATA_WIDTH    = 64,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  overflow;
  logic                  underflow;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Flags come only from registered pointers, so they lag an accepted access by one cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
  assign count = wr_ptr - rd_ptr;

  assign wr_accept = i_wr_en && !full;
  assign rd_accept = i_rd_en && !empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + PW'(1);
      if (i_wr_en && full)  overflow  <= 1'b1;
      if (i_rd_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; a write coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (wr_accept && !i_rst) mem[wr_addr] <= i_wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented straight from the read address; masked to zero while empty.
  assign o_rd_data  = empty ? '0 : mem[rd_addr];
  assign o_rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= mem[rd_addr];
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`endif

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_count        = count;
  assign o_almost_full  = (count >= AFULL_T);
  assign o_almost_empty = (count <= AEMPTY_T);
  assign o_overflow     = overflow;
  assign o_underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo in registered-read mode, DEPTH=8, DATA_WIDTH=8.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_fails  = 0;

  sync_fifo #(
    .DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_full(full), .o_empty(empty),
    .o_almost_full(almost_full), .o_almost_empty(almost_empty), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", count, i);
      chk("fill_aempty", almost_empty, (i <= 2) ? 1 : 0);
      chk("fill_afull", almost_full, (i >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    wr_en = 1'b0;

    // Overflow at full
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_count", count, 8 - i);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_valid_end", rd_valid, 0);
    chk("drain_empty", empty, 1);
    chk("drain_hold", rd_data, 8'h08);

    // Underflow
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_flag", underflow, 1);
    chk("udf_valid", rd_valid, 0);
    chk("udf_hold", rd_data, 8'h08);
    chk("udf_count", count, 0);
    chk("udf_ovf_sticky", overflow, 1);

    // Wrap with simultaneous access at count 4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
    end
    chk("wrap_pre_count", count, 4);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h14 + 8'(i);
      tick();
      chk("wrap_count", count, 4);
      chk("wrap_valid", rd_valid, 1);
      chk("wrap_data", rd_data, 8'h10 + 8'(i));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    chk("wrap_valid_end", rd_valid, 0);
    chk("wrap_count_end", count, 4);

    // Reset mid-operation at count 5 with overflow set
    wr_en = 1'b1; wr_data = 8'h40;
    tick();
    chk("mid_count", count, 5);
    chk("mid_ovf", overflow, 1);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_udf", underflow, 0);
    chk("mrst_valid", rd_valid, 0);
    chk("mrst_data", rd_data, 0);

    // Simultaneous access while empty: write wins, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h30;
    tick();
    rd_en = 1'b0;
    chk("se_count", count, 1);
    chk("se_valid", rd_valid, 0);
    chk("se_udf", underflow, 1);
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    chk("sf_pre_full", full, 1);

    // Simultaneous access while full: read wins, write rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h38;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sf_count", count, 7);
    chk("sf_valid", rd_valid, 1);
    chk("sf_data", rd_data, 8'h30);
    chk("sf_ovf", overflow, 1);
    chk("sf_full", full, 0);

    // Remaining entries 0x31..0x37 must follow; the rejected 0x38 must not appear
    for (int i = 1; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      chk("sf_drain_data", rd_data, 8'h30 + 8'(i));
    end
    rd_en = 1'b0;
    tick();
    chk("sf_drain_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
